store_xlat_queue: RTL and testbench

//  Parametrised store front-end: DEPTH-entry in-order queue between issue and store/AMO buffers.

---
 rtl/store_xlat_queue_if.sv | 65 ++++++
 rtl/store_xlat_queue.sv | 178 +++++++++++++++++
 tb/tb_store_xlat_queue.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_xlat_queue_if.sv
// Bundles the issue, translation, store/AMO dispatch and writeback signals of
// the store translation queue. The queue itself connects through the slave
// modport. The issuing side connects through the master modport.
interface store_xlat_queue_if #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned VLEN          = 39,
    parameter int unsigned PLEN          = 56,
    parameter int unsigned TRANS_ID_BITS = 3
);
    logic                     flush_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [VLEN-1:0]          vaddr_i;
    logic [XLEN-1:0]          data_i;
    logic [XLEN/8-1:0]        be_i;
    logic [1:0]               size_i;
    logic [3:0]               amo_op_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;

    logic                     translation_req_o;
    logic [VLEN-1:0]          vaddr_o;
    logic                     dtlb_hit_i;
    logic [PLEN-1:0]          paddr_i;
    logic                     ex_valid_i;

    logic                     st_valid_o;
    logic                     st_ready_i;
    logic [PLEN-1:0]          st_paddr_o;
    logic [XLEN-1:0]          st_data_o;
    logic [XLEN/8-1:0]        st_be_o;
    logic [1:0]               st_size_o;

    logic                     amo_valid_o;
    logic                     amo_ready_i;
    logic [PLEN-1:0]          amo_paddr_o;
    logic [3:0]               amo_op_o;
    logic [XLEN-1:0]          amo_data_o;
    logic [1:0]               amo_size_o;

    logic                     wb_valid_o;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic                     wb_ex_o;

    logic [11:0]              page_offset_i;
    logic                     page_offset_matches_o;
    logic                     empty_o;

    modport slave (
        input  flush_i, valid_i, vaddr_i, data_i, be_i, size_i, amo_op_i, trans_id_i,
               dtlb_hit_i, paddr_i, ex_valid_i, st_ready_i, amo_ready_i, page_offset_i,
        output ready_o, translation_req_o, vaddr_o,
               st_valid_o, st_paddr_o, st_data_o, st_be_o, st_size_o,
               amo_valid_o, amo_paddr_o, amo_op_o, amo_data_o, amo_size_o,
               wb_valid_o, wb_trans_id_o, wb_ex_o, page_offset_matches_o, empty_o
    );

    modport master (
        output flush_i, valid_i, vaddr_i, data_i, be_i, size_i, amo_op_i, trans_id_i,
               dtlb_hit_i, paddr_i, ex_valid_i, st_ready_i, amo_ready_i, page_offset_i,
        input  ready_o, translation_req_o, vaddr_o,
               st_valid_o, st_paddr_o, st_data_o, st_be_o, st_size_o,
               amo_valid_o, amo_paddr_o, amo_op_o, amo_data_o, amo_size_o,
               wb_valid_o, wb_trans_id_o, wb_ex_o, page_offset_matches_o, empty_o
    );
endinterface

// File: rtl/store_xlat_queue.sv
// In-order store front-end queue. Each entry is translated in order, one per
// cycle, and translation runs ahead of dispatch. Translated stores go to the
// store buffer and AMOs go to the AMO unit. Faulting entries retire at the
// head as an exception writeback and are never dispatched.
//
// entry state | meaning
// S_FREE      | slot unused
// S_WAIT_XLAT | queued, waiting for a DTLB hit
// S_XLATED    | physical address captured, eligible for dispatch at head
// S_EXC       | translation faulted, retires at head with wb_ex_o=1
module store_xlat_queue #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned VLEN          = 39,
    parameter int unsigned PLEN          = 56,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned DEPTH         = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    store_xlat_queue_if.slave bus
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned BW = XLEN / 8;
    localparam int unsigned OW = $clog2(BW);

    typedef enum logic [1:0] {S_FREE, S_WAIT_XLAT, S_XLATED, S_EXC} ent_state_e;

    ent_state_e               state_q [DEPTH], state_d [DEPTH];
    logic [VLEN-1:0]          vaddr_q [DEPTH], vaddr_d [DEPTH];
    logic [XLEN-1:0]          data_q  [DEPTH], data_d  [DEPTH];
    logic [BW-1:0]            be_q    [DEPTH], be_d    [DEPTH];
    logic [1:0]               size_q  [DEPTH], size_d  [DEPTH];
    logic [3:0]               op_q    [DEPTH], op_d    [DEPTH];
    logic [TRANS_ID_BITS-1:0] id_q    [DEPTH], id_d    [DEPTH];
    logic [PLEN-1:0]          paddr_q [DEPTH], paddr_d [DEPTH];
    logic [PW-1:0]            head_q, head_d, xlat_q, xlat_d, tail_q, tail_d;

    logic [IW-1:0] head_idx, xlat_idx, tail_idx;
    logic          full, empty, amo_in_queue, ready, enq, xlat_req, pop;
    logic          st_valid, amo_valid, exc_pop;

    assign head_idx = head_q[IW-1:0];
    assign xlat_idx = xlat_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];

    // Register all entry fields and the three queue pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            xlat_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                state_q[i] <= S_FREE;
                vaddr_q[i] <= '0;
                data_q[i]  <= '0;
                be_q[i]    <= '0;
                size_q[i]  <= '0;
                op_q[i]    <= '0;
                id_q[i]    <= '0;
                paddr_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            xlat_q  <= xlat_d;
            tail_q  <= tail_d;
            state_q <= state_d;
            vaddr_q <= vaddr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            size_q  <= size_d;
            op_q    <= op_d;
            id_q    <= id_d;
            paddr_q <= paddr_d;
        end
    end

    // Next state: flush wins, otherwise enqueue, translate and retire may all happen.
    always_comb begin
        head_d  = head_q;
        xlat_d  = xlat_q;
        tail_d  = tail_q;
        state_d = state_q;
        vaddr_d = vaddr_q;
        data_d  = data_q;
        be_d    = be_q;
        size_d  = size_q;
        op_d    = op_q;
        id_d    = id_q;
        paddr_d = paddr_q;
        if (bus.flush_i) begin
            head_d = '0;
            xlat_d = '0;
            tail_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) state_d[i] = S_FREE;
        end else begin
            if (enq) begin
                state_d[tail_idx] = S_WAIT_XLAT;
                vaddr_d[tail_idx] = bus.vaddr_i;
                // Stores are lane-aligned to the doubleword; AMO operands stay as issued.
                data_d[tail_idx]  = (bus.amo_op_i == 4'd0)
                                  ? (bus.data_i << {bus.vaddr_i[OW-1:0], 3'b000})
                                  : bus.data_i;
                be_d[tail_idx]    = bus.be_i;
                size_d[tail_idx]  = bus.size_i;
                op_d[tail_idx]    = bus.amo_op_i;
                id_d[tail_idx]    = bus.trans_id_i;
                tail_d            = tail_q + PW'(1);
            end
            if (xlat_req && bus.dtlb_hit_i) begin
                if (bus.ex_valid_i) begin
                    state_d[xlat_idx] = S_EXC;
                end else begin
                    state_d[xlat_idx] = S_XLATED;
                    paddr_d[xlat_idx] = bus.paddr_i;
                end
                xlat_d = xlat_q + PW'(1);
            end
            if (pop) begin
                state_d[head_idx] = S_FREE;
                head_d            = head_q + PW'(1);
            end
        end
    end

    // Outputs and handshakes, all derived from registered state plus current inputs.
    always_comb begin
        full         = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
        empty        = (head_q == tail_q);
        amo_in_queue = !empty && (op_q[head_idx] != 4'd0);
        ready        = !full && !amo_in_queue && !((bus.amo_op_i != 4'd0) && !empty);
        enq          = bus.valid_i && ready;
        xlat_req     = (state_q[xlat_idx] == S_WAIT_XLAT);
        st_valid     = !bus.flush_i && (state_q[head_idx] == S_XLATED) && (op_q[head_idx] == 4'd0);
        amo_valid    = !bus.flush_i && (state_q[head_idx] == S_XLATED) && (op_q[head_idx] != 4'd0);
        exc_pop      = !bus.flush_i && (state_q[head_idx] == S_EXC);
        pop          = (st_valid && bus.st_ready_i) || (amo_valid && bus.amo_ready_i) || exc_pop;

        bus.ready_o           = ready;
        bus.empty_o           = empty;
        bus.translation_req_o = xlat_req;
        bus.vaddr_o           = xlat_req ? vaddr_q[xlat_idx] : '0;

        bus.st_valid_o  = st_valid;
        bus.st_paddr_o  = '0;
        bus.st_data_o   = '0;
        bus.st_be_o     = '0;
        bus.st_size_o   = '0;
        if (st_valid) begin
            bus.st_paddr_o = paddr_q[head_idx];
            bus.st_data_o  = data_q[head_idx];
            bus.st_be_o    = be_q[head_idx];
            bus.st_size_o  = size_q[head_idx];
        end

        bus.amo_valid_o = amo_valid;
        bus.amo_paddr_o = '0;
        bus.amo_op_o    = '0;
        bus.amo_data_o  = '0;
        bus.amo_size_o  = '0;
        if (amo_valid) begin
            bus.amo_paddr_o = paddr_q[head_idx];
            bus.amo_op_o    = op_q[head_idx];
            bus.amo_data_o  = data_q[head_idx];
            bus.amo_size_o  = size_q[head_idx];
        end

        bus.wb_valid_o    = pop;
        bus.wb_trans_id_o = pop ? id_q[head_idx] : '0;
        bus.wb_ex_o       = exc_pop;

        bus.page_offset_matches_o = enq && (bus.vaddr_i[11:0] == bus.page_offset_i);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (state_q[i] != S_FREE && vaddr_q[i][11:0] == bus.page_offset_i)
                bus.page_offset_matches_o = 1'b1;
        end
    end
endmodule

// File: tb/tb_store_xlat_queue.sv
// Bench for store_xlat_queue: directed scenarios plus randomized traffic,
// all cycles checked against a transaction-level queue model.
module tb_store_xlat_queue;
    localparam int XLEN = 64, VLEN = 39, PLEN = 56, TIDB = 3, DEPTH = 4, BW = XLEN / 8;

    typedef struct {
        logic [VLEN-1:0] vaddr;
        logic [XLEN-1:0] data;
        logic [BW-1:0]   be;
        logic [1:0]      size;
        logic [3:0]      op;
        logic [TIDB-1:0] id;
        logic [PLEN-1:0] paddr;
        int              st;   // 0 waiting, 1 translated, 2 faulted
    } ent_t;

    typedef struct {
        int id;
        int ex;
    } wb_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    store_xlat_queue_if #(.XLEN(XLEN), .VLEN(VLEN), .PLEN(PLEN), .TRANS_ID_BITS(TIDB)) bus ();

    store_xlat_queue #(.XLEN(XLEN), .VLEN(VLEN), .PLEN(PLEN), .TRANS_ID_BITS(TIDB), .DEPTH(DEPTH)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    ent_t mq[$];
    wb_t  wb_log[$];
    int   st_log[$];
    int   enq_log[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_idle();
        bus.flush_i = 0; bus.valid_i = 0; bus.vaddr_i = '0; bus.data_i = '0; bus.be_i = '0;
        bus.size_i = 0; bus.amo_op_i = 0; bus.trans_id_i = 0; bus.dtlb_hit_i = 0;
        bus.paddr_i = '0; bus.ex_valid_i = 0; bus.st_ready_i = 0; bus.amo_ready_i = 0;
        bus.page_offset_i = '0;
    endtask

    task automatic clear_logs();
        wb_log.delete(); st_log.delete(); enq_log.delete();
    endtask

    // id of the entry that the queue is translating now, -1 if none
    function automatic int xlat_id();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].st == 0) return int'(mq[i].id);
        return -1;
    endfunction

    // One clock: inputs already driven after a negedge; check settled outputs, advance model.
    task automatic step();
        int   n, xi;
        bit   e_ready, e_req, h_x, e_st, e_amo, e_exc, e_pop, e_match;
        ent_t h, e;
        #1;
        n  = mq.size();
        xi = -1;
        for (int i = 0; i < n; i++) if (xi < 0 && mq[i].st == 0) xi = i;
        e_ready = !(n == DEPTH) && !(n > 0 && mq[0].op != 0) && !(bus.amo_op_i != 0 && n > 0);
        e_req   = (xi >= 0);
        if (n > 0) h = mq[0];
        else h = '{default: '0};
        h_x   = !bus.flush_i && n > 0 && h.st == 1;
        e_st  = h_x && h.op == 0;
        e_amo = h_x && h.op != 0;
        e_exc = !bus.flush_i && n > 0 && h.st == 2;
        e_pop = (e_st && bus.st_ready_i) || (e_amo && bus.amo_ready_i) || e_exc;
        e_match = bus.valid_i && e_ready && bus.vaddr_i[11:0] == bus.page_offset_i;
        for (int i = 0; i < n; i++) if (mq[i].vaddr[11:0] == bus.page_offset_i) e_match = 1;

        chk("ready", bus.ready_o, e_ready);
        chk("empty", bus.empty_o, n == 0);
        chk("xlat_req", bus.translation_req_o, e_req);
        chk("xlat_vaddr", bus.vaddr_o, e_req ? mq[xi].vaddr : '0);
        chk("st_valid", bus.st_valid_o, e_st);
        chk("st_paddr", bus.st_paddr_o, e_st ? h.paddr : '0);
        chk("st_data", bus.st_data_o, e_st ? h.data : '0);
        chk("st_be", bus.st_be_o, e_st ? h.be : '0);
        chk("st_size", bus.st_size_o, e_st ? h.size : '0);
        chk("amo_valid", bus.amo_valid_o, e_amo);
        chk("amo_paddr", bus.amo_paddr_o, e_amo ? h.paddr : '0);
        chk("amo_op", bus.amo_op_o, e_amo ? h.op : '0);
        chk("amo_data", bus.amo_data_o, e_amo ? h.data : '0);
        chk("amo_size", bus.amo_size_o, e_amo ? h.size : '0);
        chk("wb_valid", bus.wb_valid_o, e_pop);
        chk("wb_id", bus.wb_trans_id_o, e_pop ? h.id : '0);
        chk("wb_ex", bus.wb_ex_o, e_exc);
        chk("po_match", bus.page_offset_matches_o, e_match);

        if (bus.wb_valid_o) wb_log.push_back('{int'(bus.wb_trans_id_o), int'(bus.wb_ex_o)});
        if (bus.st_valid_o) st_log.push_back(cyc);
        if (bus.valid_i && bus.ready_o) enq_log.push_back(cyc);

        if (bus.flush_i) begin
            mq.delete();
        end else begin
            if (xi >= 0 && bus.dtlb_hit_i) begin
                if (bus.ex_valid_i) mq[xi].st = 2;
                else begin
                    mq[xi].st    = 1;
                    mq[xi].paddr = bus.paddr_i;
                end
            end
            if (e_pop) void'(mq.pop_front());
            if (bus.valid_i && e_ready) begin
                e.vaddr = bus.vaddr_i;
                // a store's bytes land at the byte lanes addressed by vaddr
                e.data  = (bus.amo_op_i == 0) ? bus.data_i * (64'd1 << (8 * int'(bus.vaddr_i[2:0])))
                                              : bus.data_i;
                e.be    = bus.be_i;
                e.size  = bus.size_i;
                e.op    = bus.amo_op_i;
                e.id    = bus.trans_id_i;
                e.paddr = '0;
                e.st    = 0;
                mq.push_back(e);
            end
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic drain(input string tag);
        bus.valid_i = 0; bus.dtlb_hit_i = 1; bus.ex_valid_i = 0;
        bus.st_ready_i = 1; bus.amo_ready_i = 1; bus.flush_i = 0;
        for (int k = 0; k < 30 && mq.size() > 0; k++) step();
        #1 chk(tag, bus.empty_o, 1'b1);
    endtask

    task automatic put_store(input logic [VLEN-1:0] va, input logic [XLEN-1:0] d, input int id);
        bus.valid_i = 1; bus.vaddr_i = va; bus.data_i = d; bus.be_i = 8'hFF;
        bus.size_i = 2'd3; bus.amo_op_i = 0; bus.trans_id_i = TIDB'(id);
    endtask

    initial begin
        int c0, c_pop;
        set_idle();
        #1;
        chk("rst_ready", bus.ready_o, 1'b1);
        chk("rst_empty", bus.empty_o, 1'b1);
        chk("rst_st_valid", bus.st_valid_o, 1'b0);
        chk("rst_wb_valid", bus.wb_valid_o, 1'b0);
        chk("rst_xlat_req", bus.translation_req_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1;

        // back-to-back stores, always hit, always ready
        set_idle(); bus.dtlb_hit_i = 1; bus.st_ready_i = 1; clear_logs(); c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            put_store(VLEN'(32'h2000 + 8 * i), XLEN'(i + 1), i);
            bus.paddr_i = PLEN'(56'h80000 + i);
            step();
        end
        bus.valid_i = 0;
        repeat (4) step();
        chk("t1_nst", st_log.size(), 4);
        for (int i = 0; i < 4 && i < st_log.size(); i++) chk("t1_st_cyc", st_log[i], c0 + 2 + i);
        chk("t1_nwb", wb_log.size(), 4);
        for (int i = 0; i < 4 && i < wb_log.size(); i++) chk("t1_wb_id", wb_log[i].id, i);

        // byte store realignment
        set_idle(); bus.dtlb_hit_i = 1; bus.st_ready_i = 1;
        bus.valid_i = 1; bus.vaddr_i = VLEN'(32'h1003); bus.data_i = 64'hAB; bus.be_i = 8'h08;
        step();
        bus.valid_i = 0; bus.paddr_i = PLEN'(56'h1003);
        step();
        #1;
        chk("t2_st_valid", bus.st_valid_o, 1'b1);
        chk("t2_st_data", bus.st_data_o, 64'hAB000000);
        chk("t2_st_be", bus.st_be_o, 8'h08);
        step();

        // fill to DEPTH while the store buffer stalls
        set_idle(); bus.dtlb_hit_i = 1; clear_logs();
        for (int i = 0; i < 4; i++) begin
            put_store(VLEN'(32'h3000 + 8 * i), XLEN'(i), i);
            step();
        end
        put_store(VLEN'(32'h3020), XLEN'(4), 4);
        #1 chk("t3_full_ready", bus.ready_o, 1'b0);
        repeat (2) step();
        bus.st_ready_i = 1; c_pop = cyc;
        step();
        step();
        bus.valid_i = 0;
        chk("t3_n_enq", enq_log.size(), 5);
        if (enq_log.size() == 5) chk("t3_5th_cyc", enq_log[4], c_pop + 1);
        drain("t3_drain");

        // AMO blocks later stores until its handshake
        set_idle(); bus.dtlb_hit_i = 1;
        bus.valid_i = 1; bus.vaddr_i = VLEN'(32'h4008); bus.data_i = 64'h1234_5678_9ABC_DEF0;
        bus.size_i = 2'd3; bus.amo_op_i = 4'd3; bus.trans_id_i = 3'd5;
        #1 chk("t4_amo_ready", bus.ready_o, 1'b1);
        step();
        put_store(VLEN'(32'h4010), XLEN'(7), 6);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_blocked", bus.ready_o, 1'b0);
            step();
        end
        bus.amo_ready_i = 1;
        step();
        bus.amo_ready_i = 0;
        #1 chk("t4_unblocked", bus.ready_o, 1'b1);
        step();
        drain("t4_drain");

        // middle entry faults
        set_idle(); bus.dtlb_hit_i = 1; bus.st_ready_i = 1; clear_logs();
        for (int i = 0; i < 8; i++) begin
            if (i < 3) put_store(VLEN'(32'h5000 + 8 * i), XLEN'(i), i);
            else bus.valid_i = 0;
            bus.ex_valid_i = (xlat_id() == 1);
            step();
        end
        chk("t5_nwb", wb_log.size(), 3);
        for (int i = 0; i < 3 && i < wb_log.size(); i++) begin
            chk("t5_wb_id", wb_log[i].id, i);
            chk("t5_wb_ex", wb_log[i].ex, i == 1);
        end
        chk("t5_nst", st_log.size(), 2);
        drain("t5_drain");

        // flush with queued entries
        set_idle();
        put_store(VLEN'(32'h6100), XLEN'(1), 1); step();
        put_store(VLEN'(32'h6234), XLEN'(2), 2); step();
        put_store(VLEN'(32'h63F8), XLEN'(3), 3); step();
        bus.valid_i = 0; bus.page_offset_i = 12'h234;
        #1 chk("t6_match_pre", bus.page_offset_matches_o, 1'b1);
        step();
        bus.flush_i = 1; bus.dtlb_hit_i = 1; bus.st_ready_i = 1;
        step();
        bus.flush_i = 0;
        #1;
        chk("t6_empty", bus.empty_o, 1'b1);
        chk("t6_match_post", bus.page_offset_matches_o, 1'b0);
        step();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            bus.valid_i     = ($urandom_range(0, 9) < 6);
            bus.amo_op_i    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            bus.vaddr_i     = {VLEN'({$urandom, $urandom}) >> 12, 12'($urandom_range(0, 7))};
            bus.data_i      = {$urandom, $urandom};
            bus.be_i        = 8'($urandom);
            bus.size_i      = 2'($urandom);
            bus.trans_id_i  = 3'($urandom);
            bus.dtlb_hit_i  = ($urandom_range(0, 9) < 7);
            bus.ex_valid_i  = ($urandom_range(0, 9) == 0);
            bus.paddr_i     = PLEN'({$urandom, $urandom});
            bus.st_ready_i  = ($urandom_range(0, 9) < 7);
            bus.amo_ready_i = ($urandom_range(0, 1) == 1);
            bus.flush_i     = ($urandom_range(0, 49) == 0);
            bus.page_offset_i = 12'($urandom_range(0, 7));
            step();
        end

        // asynchronous reset in the middle of traffic
        set_idle();
        put_store(VLEN'(32'h7000), XLEN'(9), 1); step();
        put_store(VLEN'(32'h7008), XLEN'(9), 2); step();
        set_idle();
        #3 rst_ni = 0;
        #1;
        chk("arst_empty", bus.empty_o, 1'b1);
        chk("arst_ready", bus.ready_o, 1'b1);
        chk("arst_xlat_req", bus.translation_req_o, 1'b0);
        mq.delete();
        @(negedge clk_i);
        rst_ni = 1;
        put_store(VLEN'(32'h7010), XLEN'(5), 3); bus.dtlb_hit_i = 1; bus.st_ready_i = 1;
        step();
        drain("arst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
